// File: rtl/multdiv_ctrl_if.sv
// rtl/multdiv_ctrl_if.sv - pipeline, multdiv and writeback signals of the multdiv sequencer
interface multdiv_ctrl_if;
    logic [31:0] dx_ir;
    logic [31:0] dx_a;
    logic [31:0] dx_b;
    logic        flush;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ready;
    logic [31:0] md_op_a;
    logic [31:0] md_op_b;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic        stall;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    modport master (
        input  dx_ir, dx_a, dx_b, flush, md_result, md_exception, md_ready, wb_ready,
        output md_op_a, md_op_b, ctrl_mult, ctrl_div, stall, wb_valid, wb_reg, wb_data
    );

    modport slave (
        output dx_ir, dx_a, dx_b, flush, md_result, md_exception, md_ready, wb_ready,
        input  md_op_a, md_op_b, ctrl_mult, ctrl_div, stall, wb_valid, wb_reg, wb_data
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - sequencer sharing the multi-cycle multdiv unit with the 5-stage pipeline
// Optional BUSY watchdog enabled by defining MDIV_TIMEOUT_EN.
module multdiv_ctrl #(
    parameter logic [4:0]  OP_MUL      = 5'b00110,
    parameter logic [4:0]  OP_DIV      = 5'b00111,
    parameter logic [31:0] RSTATUS_MUL = 32'd4,
    parameter logic [31:0] RSTATUS_DIV = 32'd5
`ifdef MDIV_TIMEOUT_EN
    ,
    parameter int          TIMEOUT     = 40
`endif
) (
    input  logic           clock,
    input  logic           reset,
    multdiv_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  rd_q, rd_d;
    logic [4:0]  wb_reg_q, wb_reg_d;
    logic        is_div_q, is_div_d;
    logic        md_req;
    logic        accept;
    logic        timed_out;
    logic [31:0] rstatus;
    logic        unused_ir_bits;

    assign md_req  = (bus.dx_ir[31:27] == 5'd0) &&
                     ((bus.dx_ir[6:2] == OP_MUL) || (bus.dx_ir[6:2] == OP_DIV));
    assign accept  = md_req && !bus.flush;
    assign rstatus = is_div_q ? RSTATUS_DIV : RSTATUS_MUL;
    assign unused_ir_bits = ^{bus.dx_ir[21:7], bus.dx_ir[1:0]};

`ifdef MDIV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // Fires on the TIMEOUT-th BUSY cycle without md_ready.
    assign timed_out = (cnt_q == CW'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        rd_d      = rd_q;
        is_div_d  = is_div_q;
        wb_reg_d  = wb_reg_q;
        wb_data_d = wb_data_q;
`ifdef MDIV_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_a_d   = bus.dx_a;
                    op_b_d   = bus.dx_b;
                    rd_d     = bus.dx_ir[26:22];
                    is_div_d = (bus.dx_ir[6:2] == OP_DIV);
                    state_d  = START;
                end
            end
            START: begin
                state_d = bus.flush ? IDLE : BUSY;
`ifdef MDIV_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            BUSY: begin
                // Flush beats a coincident md_ready: the aborted op never writes back.
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.md_ready) begin
                    state_d = DONE;
                    if (bus.md_exception) begin
                        wb_reg_d  = 5'd30;
                        wb_data_d = rstatus;
                    end else begin
                        wb_reg_d  = rd_q;
                        wb_data_d = bus.md_result;
                    end
                end else if (timed_out) begin
                    state_d   = DONE;
                    wb_reg_d  = 5'd30;
                    wb_data_d = rstatus;
                end else begin
`ifdef MDIV_TIMEOUT_EN
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
            DONE: begin
                if (bus.wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rd_q      <= '0;
            is_div_q  <= 1'b0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
`ifdef MDIV_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            rd_q      <= rd_d;
            is_div_q  <= is_div_d;
            wb_reg_q  <= wb_reg_d;
            wb_data_q <= wb_data_d;
`ifdef MDIV_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.md_op_a   = op_a_q;
    assign bus.md_op_b   = op_b_q;
    assign bus.wb_reg    = wb_reg_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.ctrl_mult = (state_q == START) && !is_div_q;
    assign bus.ctrl_div  = (state_q == START) && is_div_q;
    assign bus.wb_valid  = (state_q == DONE);
    // Drops in the DONE handshake cycle so the dependent instruction advances next cycle.
    assign bus.stall     = !reset && (((state_q == IDLE) && accept) ||
                                      (state_q == START) || (state_q == BUSY) ||
                                      ((state_q == DONE) && !bus.wb_ready));
endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb/tb_multdiv_ctrl.sv - self-checking bench for multdiv_ctrl (directed and randomized ops)
module tb_multdiv_ctrl;
    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;
    localparam logic [4:0] OP_ADD = 5'b00000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n_mul = 0, n_div = 0, n_xfer = 0;
    logic [31:0] xfer_data = '0;
    int   m0, d0, x0;

    multdiv_ctrl_if bus();

    multdiv_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.ctrl_mult) n_mul <= n_mul + 1;
        if (bus.ctrl_div)  n_div <= n_div + 1;
        if (!reset && bus.wb_valid && bus.wb_ready) begin
            n_xfer    <= n_xfer + 1;
            xfer_data <= bus.wb_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] alu, input logic [4:0] rd);
        return {5'd0, rd, 5'd1, 5'd2, 5'd0, alu, 2'b00};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"},   {30'd0, bus.ctrl_mult, bus.ctrl_div}, 0);
        check({tag, "_stall"},  bus.stall, 0);
        check({tag, "_valid"},  bus.wb_valid, 0);
        check({tag, "_op_a"},   bus.md_op_a, 0);
        check({tag, "_op_b"},   bus.md_op_b, 0);
        check({tag, "_wb_reg"}, bus.wb_reg, 0);
        check({tag, "_wb_dat"}, bus.wb_data, 0);
    endtask

    // IDLE cycle with the op in DX, then the START cycle.
    task automatic issue(input logic div, input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] b, input logic glitch);
        @(negedge clock);
        m0 = n_mul; d0 = n_div; x0 = n_xfer;
        bus.dx_ir = mk_ir(div ? OP_DIV : OP_MUL, rd);
        bus.dx_a  = a;
        bus.dx_b  = b;
        bus.flush = 1'b0;
        #1;
        check("issue_stall", bus.stall, 1);
        check("issue_no_pulse", {31'd0, bus.ctrl_mult | bus.ctrl_div}, 0);
        @(negedge clock);
        bus.dx_a = $urandom;
        bus.dx_b = $urandom;
        if (glitch) begin
            bus.md_ready     = 1'b1;
            bus.md_result    = 32'hBAD0BAD0;
            bus.md_exception = 1'($urandom);
        end
        #1;
        check("start_mult", bus.ctrl_mult, !div);
        check("start_div",  bus.ctrl_div, div);
        check("start_stall", bus.stall, 1);
        check("start_op_a", bus.md_op_a, a);
        check("start_op_b", bus.md_op_b, b);
    endtask

    task automatic busy(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bus.md_ready = 1'b0;
            #1;
            check("busy_stall", bus.stall, 1);
            check("busy_valid", bus.wb_valid, 0);
            check("busy_no_pulse", {31'd0, bus.ctrl_mult | bus.ctrl_div}, 0);
        end
    endtask

    task automatic deliver(input logic [31:0] result, input logic exc);
        @(negedge clock);
        bus.md_ready     = 1'b1;
        bus.md_result    = result;
        bus.md_exception = exc;
        #1;
        check("deliver_stall", bus.stall, 1);
        check("deliver_valid", bus.wb_valid, 0);
    endtask

    task automatic drain(input int hold, input logic div, input logic [4:0] exp_reg,
                         input logic [31:0] exp_data);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            bus.md_ready  = 1'b0;
            bus.md_result = $urandom;
            bus.wb_ready  = 1'b0;
            #1;
            check("hold_valid", bus.wb_valid, 1);
            check("hold_reg", bus.wb_reg, exp_reg);
            check("hold_data", bus.wb_data, exp_data);
            check("hold_stall", bus.stall, 1);
        end
        @(negedge clock);
        bus.md_ready = 1'b0;
        bus.wb_ready = 1'b1;
        #1;
        check("wb_valid", bus.wb_valid, 1);
        check("wb_reg", bus.wb_reg, exp_reg);
        check("wb_data", bus.wb_data, exp_data);
        check("wb_stall_low", bus.stall, 0);
        @(posedge clock);
        #1;
        bus.dx_ir    = 32'd0;
        bus.wb_ready = 1'($urandom);
        #1;
        check("post_valid_low", bus.wb_valid, 0);
        check("xfer_once", n_xfer - x0, 1);
        check("mult_pulses", n_mul - m0, div ? 0 : 1);
        check("div_pulses", n_div - d0, div ? 1 : 0);
    endtask

    // Reference: the bench plays the multdiv unit and predicts the committed writeback.
    task automatic do_op(input logic div, input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic exc_in,
                         input int hold, input logic glitch);
        logic [31:0] result;
        logic        exc;
        exc    = exc_in || (div && b == 0);
        result = div ? ((b == 0) ? 32'd0 : a / b) : a * b;
        issue(div, rd, a, b, glitch);
        busy(lat);
        deliver(result, exc);
        drain(hold, div, exc ? 5'd30 : rd, exc ? (div ? 32'd5 : 32'd4) : result);
    endtask

    initial begin
        int cyc;
        logic [31:0] r3;
        bus.dx_ir = '0; bus.dx_a = '0; bus.dx_b = '0; bus.flush = 1'b0;
        bus.md_result = '0; bus.md_exception = 1'b0; bus.md_ready = 1'b0; bus.wb_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;

        do_op(1'b0, 5'd3, 32'd6, 32'd7, 17, 1'b0, 0, 1'b0);
        r3 = xfer_data;
        bus.dx_ir = mk_ir(OP_ADD, 5'd5);
        #1;
        check("dep_add_not_stalled", bus.stall, 0);
        check("dep_add_r5", r3 + r3, 32'd84);
        @(negedge clock);
        bus.dx_ir = '0;

        do_op(1'b1, 5'd4, 32'd5, 32'd0, 10, 1'b1, 0, 1'b1);
        do_op(1'b0, 5'd7, 32'd11, 32'd13, 5, 1'b0, 3, 1'b0);
        do_op(1'b0, 5'd0, 32'd9, 32'd9, 3, 1'b0, 1, 1'b0);

        // flush in IDLE suppresses the accept
        @(negedge clock);
        bus.dx_ir = mk_ir(OP_MUL, 5'd3);
        bus.flush = 1'b1;
        #1;
        check("idle_flush_stall", bus.stall, 0);
        @(negedge clock);
        bus.dx_ir = '0;
        bus.flush = 1'b0;
        #1;
        check("idle_flush_no_pulse", {31'd0, bus.ctrl_mult | bus.ctrl_div}, 0);

        // flush 4 cycles into BUSY, then a stray md_ready
        issue(1'b0, 5'd3, 32'd1, 32'd1, 1'b0);
        busy(4);
        @(negedge clock);
        bus.flush = 1'b1;
        bus.dx_ir = '0;
        @(negedge clock);
        bus.flush     = 1'b0;
        bus.md_ready  = 1'b1;
        bus.md_result = 32'hDEAD;
        #1;
        check("flush_valid", bus.wb_valid, 0);
        check("flush_stall", bus.stall, 0);
        @(negedge clock);
        bus.md_ready = 1'b0;
        #1;
        check("flush_stray_valid", bus.wb_valid, 0);
        check("flush_no_xfer", n_xfer - x0, 0);
        do_op(1'b0, 5'd6, 32'd2, 32'd3, 4, 1'b0, 0, 1'b0);

        // flush and md_ready together in BUSY: flush wins
        issue(1'b1, 5'd8, 32'd100, 32'd7, 1'b0);
        busy(2);
        @(negedge clock);
        bus.flush     = 1'b1;
        bus.md_ready  = 1'b1;
        bus.md_result = 32'd14;
        bus.dx_ir     = '0;
        @(negedge clock);
        bus.flush    = 1'b0;
        bus.md_ready = 1'b0;
        #1;
        check("flush_ready_valid", bus.wb_valid, 0);
        check("flush_ready_stall", bus.stall, 0);

        // flush in DONE is ignored
        issue(1'b0, 5'd9, 32'd4, 32'd5, 1'b0);
        busy(1);
        deliver(32'd20, 1'b0);
        @(negedge clock);
        bus.md_ready = 1'b0;
        bus.flush    = 1'b1;
        bus.wb_ready = 1'b1;
        #1;
        check("done_flush_valid", bus.wb_valid, 1);
        check("done_flush_data", bus.wb_data, 32'd20);
        @(negedge clock);
        bus.flush    = 1'b0;
        bus.wb_ready = 1'b0;
        bus.dx_ir    = '0;
        check("done_flush_xfer", n_xfer - x0, 1);

        // reset mid-BUSY
        issue(1'b0, 5'd10, 32'h1234, 32'h5678, 1'b0);
        busy(3);
        @(negedge clock);
        reset     = 1'b1;
        bus.dx_ir = '0;
        @(negedge clock);
        check_all_zero("mid_reset");
        reset = 1'b0;

`ifdef MDIV_TIMEOUT_EN
        issue(1'b0, 5'd11, 32'd3, 32'd3, 1'b0);
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clock);
            bus.md_ready = 1'b0;
            #1;
            if (bus.wb_valid) break;
            cyc++;
        end
        check("timeout_cycles", cyc, 40);
        check("timeout_reg", bus.wb_reg, 5'd30);
        check("timeout_data", bus.wb_data, 32'd4);
        bus.wb_ready = 1'b1;
        @(negedge clock);
        bus.wb_ready  = 1'b0;
        bus.dx_ir     = '0;
        bus.md_ready  = 1'b1;
        bus.md_result = 32'd9;
        @(negedge clock);
        bus.md_ready = 1'b0;
        #1;
        check("timeout_stray_valid", bus.wb_valid, 0);
        check("timeout_xfer", n_xfer - x0, 1);
`else
        cyc = 0;
        issue(1'b0, 5'd11, 32'd3, 32'd3, 1'b0);
        busy(60);
        deliver(32'd9, 1'b0);
        drain(0, 1'b0, 5'd11, 32'd9);
`endif

        for (int i = 0; i < 20; i++) begin
            logic        div;
            logic [31:0] a, b;
            div = 1'($urandom);
            a   = $urandom;
            b   = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            do_op(div, 5'($urandom), a, b, $urandom_range(0, 8),
                  ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
